btn_event_arbiter: RTL

Collects debounced button levels from N `debounce` instances and turns them into a serialized stream of press events. Each rising edge latches a pending request per channel. A round-robin arbiter offers one event at a time to the scheduler front-end over a valid/ready handshake. It sits between the button debouncers and the task-release logic of the RMS scheduler.

---
 rtl/btn_arb_pkg.sv | 12 +
 rtl/rr_pick.sv | 28 ++
 rtl/btn_event_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/btn_arb_pkg.sv
// Shared FSM state type and default auto-repeat timing (50 MHz clock) for the button event arbiter.
package btn_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_t;

  localparam int REPEAT_DLY_DEF = 50_000_000;
  localparam int REPEAT_PER_DEF = 10_000_000;

endpackage

// File: rtl/rr_pick.sv
// Round-robin selector: first set request at or after (last+1) mod N, wrapping to 0.
// Purely combinational, zero latency; no backpressure (caller decides when to use grant).
module rr_pick #(
  parameter  int N   = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last,
  output logic [IDW-1:0] grant_id,
  output logic           any
);

  always_comb begin
    int idx;
    idx      = 0;
    grant_id = '0;
    any      = 1'b0;
    for (int i = 1; i <= N; i++) begin
      idx = int'(last) + i;
      if (idx >= N) idx = idx - N;
      if (!any && req[IDW'(idx)]) begin
        any      = 1'b1;
        grant_id = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/btn_event_arbiter.sv
// Turns debounced button levels into a round-robin stream of press events; BTN_AUTO_REPEAT_EN adds held-key repeats.
// Latency: rise in cycle t -> o_PENDING at t+1, o_VALID/o_ID at t+2; at most one event per 2 cycles.
// Backpressure: o_ID holds until i_READY; further presses on a pending channel coalesce and pulse o_DROP.
module btn_event_arbiter
  import btn_arb_pkg::*;
#(
  parameter  int N          = 4,
  parameter  int REPEAT_DLY = REPEAT_DLY_DEF,
  parameter  int REPEAT_PER = REPEAT_PER_DEF,
  localparam int IDW        = $clog2(N)
) (
  input  logic           i_CLK,
  input  logic           i_RST_N,
  input  logic [N-1:0]   i_DB,
  output logic           o_VALID,
  output logic [IDW-1:0] o_ID,
  input  logic           i_READY,
  output logic [N-1:0]   o_PENDING,
  output logic           o_DROP
);

  arb_state_t     state, state_nxt;
  logic [N-1:0]   prev, pend, pend_nxt, rise, evt, acc_mask, drop_vec;
  logic [IDW-1:0] id_q, id_nxt, last, last_nxt, grant_id;
  logic           any, accept, drop_q;

  assign rise = i_DB & ~prev;

`ifdef BTN_AUTO_REPEAT_EN
  localparam int             CW         = $clog2(REPEAT_DLY + 1);
  localparam logic [CW-1:0]  CNT_FIRE   = CW'(REPEAT_DLY - 1);
  localparam logic [CW-1:0]  CNT_RELOAD = CW'(REPEAT_DLY - REPEAT_PER);

  logic [CW-1:0] rpt_cnt [N];
  logic [N-1:0]  rpt;

  // Fires on the cycle the count would reach REPEAT_DLY, so repeats line up with the press cycle.
  always_comb begin
    rpt = '0;
    for (int k = 0; k < N; k++)
      rpt[k] = i_DB[k] && !rise[k] && (rpt_cnt[k] == CNT_FIRE);
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      for (int k = 0; k < N; k++) rpt_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (rise[k] || !i_DB[k])         rpt_cnt[k] <= '0;
        else if (rpt_cnt[k] == CNT_FIRE) rpt_cnt[k] <= CNT_RELOAD;
        else                             rpt_cnt[k] <= rpt_cnt[k] + 1'b1;
      end
    end
  end

  assign evt = rise | rpt;
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^(REPEAT_DLY ^ REPEAT_PER);
  assign evt = rise;
`endif

  assign accept = (state == OFFER) && i_READY;

  always_comb begin
    acc_mask = '0;
    if (accept) acc_mask[id_q] = 1'b1;
  end

  // A new event on the channel being accepted re-arms it instead of coalescing.
  assign drop_vec = evt & pend & ~acc_mask;
  assign pend_nxt = (pend & ~acc_mask) | evt;

  rr_pick #(.N(N)) u_rr_pick (
    .req      (pend),
    .last     (last),
    .grant_id (grant_id),
    .any      (any)
  );

  always_comb begin
    state_nxt = state;
    id_nxt    = id_q;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (any) begin
          state_nxt = OFFER;
          id_nxt    = grant_id;
        end
      end
      OFFER: begin
        if (i_READY) begin
          state_nxt = IDLE;
          last_nxt  = id_q;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) state <= IDLE;
    else          state <= state_nxt;
  end

  // prev resets high so a button held through reset must be released before it counts.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      prev   <= '1;
      pend   <= '0;
      id_q   <= '0;
      last   <= IDW'(N - 1);
      drop_q <= 1'b0;
    end else begin
      prev   <= i_DB;
      pend   <= pend_nxt;
      id_q   <= id_nxt;
      last   <= last_nxt;
      drop_q <= |drop_vec;
    end
  end

  assign o_VALID   = (state == OFFER);
  assign o_ID      = id_q;
  assign o_PENDING = pend;
  assign o_DROP    = drop_q;

endmodule
